// File: rtl/core_v_mcu_pkg.sv
// Shared bus-subsystem types and constants for the 32-bit register interface.
// Provides reg request/response structs, reg watchdog defaults and guard FSM states.
package core_v_mcu_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    localparam int unsigned RegTimeoutCycles  = 1024;
    localparam logic [31:0] RegTimeoutErrData = 32'hBADCAB1E;

    typedef enum logic [1:0] {
        GuardIdle,
        GuardActive,
        GuardErrRsp,
        GuardDrain
    } guard_state_e;

endpackage

// File: rtl/reg_timeout_guard.sv
// Per-port reg watchdog: zero-latency passthrough, aborts stalled requests with an
// error upstream and isolates the port until the peripheral finally completes.
// Ports: clk_i, rst_ni (async low); slv_req_i/slv_rsp_o upstream side;
// mst_req_o/mst_rsp_i peripheral side; timeout_o pulse, isolated_o, timeout_count_o.
module reg_timeout_guard
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned TimeoutCycles = RegTimeoutCycles,
    parameter logic [31:0] ErrData       = RegTimeoutErrData,
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  req_t        slv_req_i,
    output rsp_t        slv_rsp_o,
    output req_t        mst_req_o,
    input  rsp_t        mst_rsp_i,
    output logic        timeout_o,
    output logic        isolated_o,
    output logic [15:0] timeout_count_o
);

    if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_bad_timeout
        $error("reg_timeout_guard: TimeoutCycles must be within 2..65535");
    end

    localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

    guard_state_e state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  timeout_count_q, timeout_count_d;
    req_t         req_q, req_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= GuardIdle;
            cnt_q           <= '0;
            timeout_count_q <= '0;
            req_q           <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            timeout_count_q <= timeout_count_d;
            req_q           <= req_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        timeout_count_d = timeout_count_q;
        req_d           = req_q;
        unique case (state_q)
            GuardIdle: begin
                if (slv_req_i.valid && !mst_rsp_i.ready) begin
                    req_d   = slv_req_i;
                    cnt_d   = 16'd1;
                    state_d = GuardActive;
                end
            end
            GuardActive: begin
                if (mst_rsp_i.ready) begin
                    cnt_d   = '0;
                    state_d = GuardIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = GuardErrRsp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GuardErrRsp: begin
                cnt_d = '0;
                if (timeout_count_q != 16'hFFFF) begin
                    timeout_count_d = timeout_count_q + 16'd1;
                end
                // A response landing in the abort cycle is dropped; upstream
                // already sees the error, so there is nothing left to drain.
                state_d = mst_rsp_i.ready ? GuardIdle : GuardDrain;
            end
            GuardDrain: begin
                if (mst_rsp_i.ready) begin
                    state_d = GuardIdle;
                end
            end
            default: state_d = GuardIdle;
        endcase
    end

    always_comb begin
        mst_req_o  = slv_req_i;
        slv_rsp_o  = mst_rsp_i;
        timeout_o  = 1'b0;
        isolated_o = 1'b0;
        unique case (state_q)
            GuardIdle: begin
            end
            GuardActive: begin
                mst_req_o       = req_q;
                mst_req_o.valid = 1'b1;
            end
            GuardErrRsp: begin
                mst_req_o       = req_q;
                mst_req_o.valid = 1'b1;
                slv_rsp_o.rdata = ErrData;
                slv_rsp_o.error = 1'b1;
                slv_rsp_o.ready = 1'b1;
                timeout_o       = 1'b1;
                isolated_o      = 1'b1;
            end
            GuardDrain: begin
                // Peripheral keeps the stuck request; new upstream requests
                // are refused in the same cycle and never forwarded.
                mst_req_o       = req_q;
                mst_req_o.valid = 1'b1;
                slv_rsp_o.rdata = ErrData;
                slv_rsp_o.error = slv_req_i.valid;
                slv_rsp_o.ready = slv_req_i.valid;
                isolated_o      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign timeout_count_o = timeout_count_q;

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Directed self-checking bench for reg_timeout_guard with TimeoutCycles = 8.
// Inputs driven at the falling edge; outputs sampled 1 time unit later.
module tb_reg_timeout_guard;
    import core_v_mcu_pkg::*;

    logic        clk;
    logic        rst_n;
    reg_req_t    slv_req;
    reg_rsp_t    slv_rsp;
    reg_req_t    mst_req;
    reg_rsp_t    mst_rsp;
    logic        timeout;
    logic        isolated;
    logic [15:0] tcount;

    int checks = 0;
    int errors = 0;

    reg_rsp_t err_rsp;
    reg_rsp_t exp_rsp;
    logic [15:0] sat_exp [3];

    reg_timeout_guard #(.TimeoutCycles(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .slv_req_i       (slv_req),
        .slv_rsp_o       (slv_rsp),
        .mst_req_o       (mst_req),
        .mst_rsp_i       (mst_rsp),
        .timeout_o       (timeout),
        .isolated_o      (isolated),
        .timeout_count_o (tcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata);
        slv_req.addr  = addr;
        slv_req.write = wr;
        slv_req.wdata = wdata;
        slv_req.wstrb = wr ? 4'hF : 4'h0;
        slv_req.valid = 1'b1;
    endtask

    // Request at cycle 0, peripheral silent until cycle 8 (the abort cycle),
    // where it answers together with the error response.
    task automatic timeout_fast(input logic [31:0] addr,
                                input logic [15:0] exp_cnt);
        tick();
        drive_req(addr, 1'b0, 32'h0);
        mst_rsp = '0;
        repeat (8) tick();
        mst_rsp.ready = 1'b1;
        #1;
        chk("sat_err_rsp", 128'(slv_rsp), 128'(err_rsp));
        chk("sat_timeout", 128'(timeout), 128'(1'b1));
        tick();
        slv_req.valid = 1'b0;
        mst_rsp.ready = 1'b0;
        #1;
        chk("sat_count", 128'(tcount), 128'(exp_cnt));
        chk("sat_isolated", 128'(isolated), 128'(1'b0));
    endtask

    initial begin
        err_rsp = '{rdata: 32'hBADCAB1E, error: 1'b1, ready: 1'b1};
        rst_n   = 1'b0;
        slv_req = '0;
        mst_rsp = '0;

        // reset: passthrough and cleared state
        tick();
        slv_req.addr  = 32'h0000_0ABC;
        mst_rsp.rdata = 32'h0F0F_0F0F;
        #1;
        chk("rst_timeout", 128'(timeout), 128'(1'b0));
        chk("rst_isolated", 128'(isolated), 128'(1'b0));
        chk("rst_count", 128'(tcount), 128'(16'h0));
        chk("rst_req_pass", 128'(mst_req), 128'(slv_req));
        chk("rst_rsp_pass", 128'(slv_rsp), 128'(mst_rsp));
        tick();
        rst_n   = 1'b1;
        slv_req = '0;
        mst_rsp = '0;

        // read answered in cycle 0
        tick();
        drive_req(32'h0000_0100, 1'b0, 32'h0);
        mst_rsp = '{rdata: 32'h1234_5678, error: 1'b0, ready: 1'b1};
        #1;
        exp_rsp = '{rdata: 32'h1234_5678, error: 1'b0, ready: 1'b1};
        chk("rd0_rsp", 128'(slv_rsp), 128'(exp_rsp));
        chk("rd0_req", 128'(mst_req), 128'(slv_req));
        chk("rd0_timeout", 128'(timeout), 128'(1'b0));
        tick();
        slv_req.valid = 1'b0;
        mst_rsp.ready = 1'b0;
        #1;
        chk("rd0_idle", 128'(mst_req.valid), 128'(1'b0));

        // write answered in cycle 7 (last legal cycle)
        tick();
        drive_req(32'h0000_0200, 1'b1, 32'hA5A5_A5A5);
        #1;
        chk("wr7_c0_req", 128'(mst_req), 128'(slv_req));
        repeat (6) tick();
        #1;
        chk("wr7_c6_addr", 128'(mst_req.addr), 128'(32'h0000_0200));
        chk("wr7_c6_valid", 128'(mst_req.valid), 128'(1'b1));
        tick();
        mst_rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
        #1;
        chk("wr7_c7_ready", 128'(slv_rsp.ready), 128'(1'b1));
        chk("wr7_c7_error", 128'(slv_rsp.error), 128'(1'b0));
        chk("wr7_c7_timeout", 128'(timeout), 128'(1'b0));
        tick();
        slv_req.valid = 1'b0;
        mst_rsp.ready = 1'b0;
        #1;
        chk("wr7_idle", 128'(mst_req.valid), 128'(1'b0));
        chk("wr7_count", 128'(tcount), 128'(16'h0));
        chk("wr7_isolated", 128'(isolated), 128'(1'b0));

        // peripheral stuck: timeout at cycle 8, drain until cycle 20
        tick();
        drive_req(32'h0000_0300, 1'b1, 32'hCAFE_F00D);
        mst_rsp = '0;
        repeat (7) tick();
        #1;
        chk("to_c7_timeout", 128'(timeout), 128'(1'b0));
        chk("to_c7_ready", 128'(slv_rsp.ready), 128'(1'b0));
        tick();
        #1;
        chk("to_c8_rsp", 128'(slv_rsp), 128'(err_rsp));
        chk("to_c8_timeout", 128'(timeout), 128'(1'b1));
        chk("to_c8_isolated", 128'(isolated), 128'(1'b1));
        chk("to_c8_count", 128'(tcount), 128'(16'h0));
        tick();
        slv_req.valid = 1'b0;
        #1;
        chk("to_c9_count", 128'(tcount), 128'(16'h1));
        chk("to_c9_timeout", 128'(timeout), 128'(1'b0));
        chk("to_c9_isolated", 128'(isolated), 128'(1'b1));
        chk("to_c9_ready", 128'(slv_rsp.ready), 128'(1'b0));
        chk("to_c9_mvalid", 128'(mst_req.valid), 128'(1'b1));
        repeat (3) tick();
        drive_req(32'h0000_0400, 1'b0, 32'h0);
        #1;
        chk("dr_c12_rsp", 128'(slv_rsp), 128'(err_rsp));
        chk("dr_c12_addr", 128'(mst_req.addr), 128'(32'h0000_0300));
        tick();
        slv_req.valid = 1'b0;
        repeat (7) tick();
        mst_rsp = '{rdata: 32'h0000_0077, error: 1'b0, ready: 1'b1};
        #1;
        chk("dr_c20_hold", 128'({mst_req.addr, mst_req.wdata}),
            128'({32'h0000_0300, 32'hCAFE_F00D}));
        chk("dr_c20_mvalid", 128'(mst_req.valid), 128'(1'b1));
        chk("dr_c20_noready", 128'(slv_rsp.ready), 128'(1'b0));
        tick();
        drive_req(32'h0000_0500, 1'b0, 32'h0);
        mst_rsp = '{rdata: 32'h55AA_33CC, error: 1'b0, ready: 1'b1};
        #1;
        exp_rsp = '{rdata: 32'h55AA_33CC, error: 1'b0, ready: 1'b1};
        chk("dr_c21_rsp", 128'(slv_rsp), 128'(exp_rsp));
        chk("dr_c21_req", 128'(mst_req), 128'(slv_req));
        chk("dr_c21_isolated", 128'(isolated), 128'(1'b0));
        tick();
        slv_req.valid = 1'b0;
        mst_rsp.ready = 1'b0;

        // ready coincides with the abort cycle
        tick();
        drive_req(32'h0000_0600, 1'b0, 32'h0);
        mst_rsp = '0;
        repeat (8) tick();
        mst_rsp = '{rdata: 32'h1111_1111, error: 1'b0, ready: 1'b1};
        #1;
        chk("co_c8_rsp", 128'(slv_rsp), 128'(err_rsp));
        tick();
        slv_req.valid = 1'b0;
        mst_rsp.ready = 1'b0;
        #1;
        chk("co_c9_isolated", 128'(isolated), 128'(1'b0));
        chk("co_c9_count", 128'(tcount), 128'(16'h2));
        chk("co_c9_idle", 128'(mst_req.valid), 128'(1'b0));

        // reset asserted in the middle of ACTIVE
        tick();
        drive_req(32'h0000_0700, 1'b0, 32'h0);
        mst_rsp = '0;
        repeat (3) tick();
        #1;
        chk("ra_active_addr", 128'(mst_req.addr), 128'(32'h0000_0700));
        rst_n         = 1'b0;
        slv_req.addr  = 32'h0000_0704;
        slv_req.valid = 1'b0;
        #1;
        chk("ra_pass_req", 128'(mst_req), 128'(slv_req));
        chk("ra_count", 128'(tcount), 128'(16'h0));
        chk("ra_isolated", 128'(isolated), 128'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        drive_req(32'h0000_0800, 1'b0, 32'h0);
        mst_rsp = '{rdata: 32'hDEAD_BEEF, error: 1'b0, ready: 1'b1};
        #1;
        exp_rsp = '{rdata: 32'hDEAD_BEEF, error: 1'b0, ready: 1'b1};
        chk("ra_after_rsp", 128'(slv_rsp), 128'(exp_rsp));
        tick();
        slv_req.valid = 1'b0;
        mst_rsp.ready = 1'b0;

        // saturation: preload counter near the top, then real timeouts
        tick();
        force dut.timeout_count_q = 16'hFFFD;
        #1;
        release dut.timeout_count_q;
        #1;
        chk("sat_preload", 128'(tcount), 128'(16'hFFFD));
        sat_exp[0] = 16'hFFFE;
        sat_exp[1] = 16'hFFFF;
        sat_exp[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            timeout_fast(32'h0000_0900 + 32'(i), sat_exp[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
